selector_arb_2ph: RTL and testbench
===================================

Name: selector_arb_2ph

Overview:
Synchronous two-phase (transition-signalling) arbitrated selector. Two requester channels compete for one shared output side; the block grants one at a time and drives a shared data bus with the winner's data. It combines an arbiter (r/a input channels, g/d output channels) and a data selector in one clocked block. It sits between two two-phase event sources and two downstream consumers that share the dataout bus.

Parameters:
WIDTH, 8, width of datain1, datain2 and dataout.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rstn  input  1  reset; synchronous, active-low.
r1  input  1  port-1 request; each toggle is one new request.
a1  output  1  port-1 acknowledge; toggles once per completed request.
r2  input  1  port-2 request; each toggle is one new request.
a2  output  1  port-2 acknowledge.
g1  output  1  grant to output channel 1; toggles to start a transfer.
d1  input  1  done from output channel 1; toggles to match g1 when finished.
g2  output  1  grant to output channel 2.
d2  input  1  done from output channel 2.
datain1  input  WIDTH  data for port 1.
datain2  input  WIDTH  data for port 2.
dataout  output  WIDTH  registered data of the most recently granted port.

Behaviour:
- All inputs are synchronous to clk; no internal synchronisers.
- Pending request: p1 = r1 ^ a1, p2 = r2 ^ a2. Busy output channel x: gx ^ dx.
- Reset (rstn=0 at a rising edge): a1=a2=g1=g2=0, dataout=0, state IDLE, priority pointer = port 1. Reset has priority over every other event, including mid-transfer; any in-flight transfer is abandoned.
- State machine states: IDLE, BUSY1, BUSY2.
- IDLE:
  - Only p1 set: g1 toggles, dataout<=datain1, go to BUSY1.
  - Only p2 set: g2 toggles, dataout<=datain2, go to BUSY2.
  - Both set: the port named by the priority pointer wins, handled as above.
  - Neither set: hold.
- BUSY1: wait until d1==g1. On that edge a1 toggles, pointer<=port 2, go to IDLE.
- BUSY2: wait until d2==g2. On that edge a2 toggles, pointer<=port 1, go to IDLE.
- Latency:
  - Request toggle sampled at edge N produces the grant toggle and dataout update at edge N (registered outputs, visible after edge N).
  - Done sampled at edge M produces the ack toggle at edge M.
  - The earliest next grant is edge M+1.
- Mutual exclusion: at most one of (g1^d1), (g2^d2) is ever 1. At most one of g1/g2 toggles per cycle.
- Round-robin: under continuous contention, grants alternate 1,2,1,2…
- dataout changes only on a grant edge. It holds between grants and is not re-sampled if datain changes mid-transfer.
- A request that toggles again before being acknowledged (protocol violation) simply keeps px unchanged or clears it. The block acts on the current XOR value only.
- A d toggle while not in the matching BUSY state is ignored. No state change.
- No internal counters; no overflow/wrap conditions beyond 1-bit toggle parity.

Test Plan:
- Reset: hold rstn=0 two cycles with r1/r2/d1/d2 toggling -> a1=a2=g1=g2=0, dataout=0x00 throughout.
- Single port-1 request: datain1=0xAA, toggle r1 before edge N -> g1=1 and dataout=0xAA after edge N. Loop d1=g1 after 3 cycles -> a1=1 at that edge, p1=0.
- Single port-2 request: datain2=0x55, r2 toggles -> g2 toggles, dataout=0x55. Ack follows d2 with a 10-cycle done delay; a2 is unchanged before d2 matches.
- Simultaneous request after reset: r1 and r2 toggle in the same cycle -> port 1 is granted first (dataout=0xAA), then port 2 (0x55), each acked exactly once.
- Continuous contention: two self-retoggling requesters, d1=g1 delayed 1 cycle, d2=g2 delayed 5 cycles, 1000 transfers -> grants strictly alternate. (g1^d1)&(g2^d2) is never 1. Ack count per port is equal ±1.
- Mid-transfer reset: rstn=0 while in BUSY2 -> all outputs 0 next edge. After release and a fresh r1 toggle, port 1 is granted normally.

Source files
------------

// File: rtl/selector_arb_2ph_if.sv
// Handshake and data bundle for the two-phase arbitrated selector.
// slave = arbiter side, master = environment (requesters + consumers).
interface selector_arb_2ph_if #(
  parameter int WIDTH = 8
);
  logic             r1, a1, r2, a2;
  logic             g1, d1, g2, d2;
  logic [WIDTH-1:0] datain1, datain2, dataout;

  modport slave (
    input  r1, r2, d1, d2, datain1, datain2,
    output a1, a2, g1, g2, dataout
  );

  modport master (
    output r1, r2, d1, d2, datain1, datain2,
    input  a1, a2, g1, g2, dataout
  );
endinterface

// File: rtl/selector_arb_2ph.sv
// Two-phase (transition-signalling) arbitrated selector: two request
// channels share one data bus and two grant/done output channels.
// A request is pending while r^a is set; an output channel is busy while
// g^d is set. Round-robin between ports on contention.
module selector_arb_2ph #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rstn,
  selector_arb_2ph_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY1 = 2'd1;
  localparam logic [1:0] BUSY2 = 2'd2;

  logic [1:0]       state_q;
  logic             ptr_q;      // 0: port 1 has priority, 1: port 2
  logic             a1_q, a2_q, g1_q, g2_q;
  logic [WIDTH-1:0] dout_q;
  logic             p1, p2, pick1;

  assign p1    = bus.r1 ^ a1_q;
  assign p2    = bus.r2 ^ a2_q;
  // port 1 wins when alone, or when both pend and the pointer favours it
  assign pick1 = p1 && (!p2 || !ptr_q);

  assign bus.a1      = a1_q;
  assign bus.a2      = a2_q;
  assign bus.g1      = g1_q;
  assign bus.g2      = g2_q;
  assign bus.dataout = dout_q;

  // Arbitration FSM: grant from IDLE, ack and rotate priority on done.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick1) begin
            g1_q    <= ~g1_q;
            dout_q  <= bus.datain1;
            state_q <= BUSY1;
          end else if (p2) begin
            g2_q    <= ~g2_q;
            dout_q  <= bus.datain2;
            state_q <= BUSY2;
          end
        end
        BUSY1: begin
          if (bus.d1 == g1_q) begin
            a1_q    <= ~a1_q;
            ptr_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        BUSY2: begin
          if (bus.d2 == g2_q) begin
            a2_q    <= ~a2_q;
            ptr_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_selector_arb_2ph.sv
// Directed bench for selector_arb_2ph: reset, single requests on each
// port, simultaneous requests, long contention run, reset mid-transfer.
module tb_selector_arb_2ph;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  selector_arb_2ph_if #(.WIDTH(8)) bus ();
  selector_arb_2ph #(.WIDTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // advance one rising edge, then settle so outputs are sampled off-edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hs();
    return {bus.a1, bus.a2, bus.g1, bus.g2};
  endfunction

  initial begin
    int n_grant, exp_port, w1, w2, n_ack1, n_ack2, cyc, diff;
    logic pg1, pg2, pa1, pa2;

    rstn = 1'b0;
    bus.r1 = 0; bus.r2 = 0; bus.d1 = 0; bus.d2 = 0;
    bus.datain1 = 8'h00; bus.datain2 = 8'h00;

    // reset held two cycles with inputs toggling
    tick();
    bus.r1 = 1; bus.r2 = 1; bus.d1 = 1; bus.d2 = 1;
    tick();
    chk("rst_hs0", hs(), 4'b0000);
    chk("rst_do0", bus.dataout, 8'h00);
    bus.r1 = 0; bus.r2 = 0; bus.d1 = 0; bus.d2 = 0;
    tick();
    chk("rst_hs1", hs(), 4'b0000);
    chk("rst_do1", bus.dataout, 8'h00);

    // single port-1 request, done looped back after 3 cycles
    rstn = 1'b1;
    tick();
    chk("idle_hs", hs(), 4'b0000);
    bus.datain1 = 8'hAA; bus.r1 = 1;
    tick();
    chk("p1_grant", hs(), 4'b0010);
    chk("p1_do", bus.dataout, 8'hAA);
    bus.datain1 = 8'h11;
    tick(); tick();
    chk("p1_wait", hs(), 4'b0010);
    bus.d1 = 1;
    tick();
    chk("p1_ack", hs(), 4'b1010);
    tick();
    chk("p1_idle", hs(), 4'b1010);
    chk("p1_do_hold", bus.dataout, 8'hAA);

    // single port-2 request, 10-cycle done delay, data changes mid-transfer
    bus.datain2 = 8'h55; bus.r2 = 1;
    tick();
    chk("p2_grant", hs(), 4'b1011);
    chk("p2_do", bus.dataout, 8'h55);
    bus.datain2 = 8'h77;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("p2_wait", hs(), 4'b1011);
      chk("p2_do_hold", bus.dataout, 8'h55);
    end
    bus.d2 = 1;
    tick();
    chk("p2_ack", hs(), 4'b1111);

    // simultaneous requests after a fresh reset: port 1 first, then port 2
    rstn = 1'b0;
    bus.r1 = 0; bus.r2 = 0; bus.d1 = 0; bus.d2 = 0;
    tick();
    chk("rst2_hs", hs(), 4'b0000);
    rstn = 1'b1;
    bus.datain1 = 8'hAA; bus.datain2 = 8'h55;
    bus.r1 = 1; bus.r2 = 1;
    tick();
    chk("sim_g1", hs(), 4'b0010);
    chk("sim_do1", bus.dataout, 8'hAA);
    bus.d1 = 1;
    tick();
    chk("sim_a1", hs(), 4'b1010);
    tick();
    chk("sim_g2", hs(), 4'b1011);
    chk("sim_do2", bus.dataout, 8'h55);
    bus.d2 = 1;
    tick();
    chk("sim_a2", hs(), 4'b1111);
    tick(); tick();
    chk("sim_once", hs(), 4'b1111);

    // continuous contention: self-retoggling requesters, d1 lags 1, d2 lags 5
    n_grant = 0; exp_port = 1; w1 = 0; w2 = 0; n_ack1 = 0; n_ack2 = 0; cyc = 0;
    pg1 = bus.g1; pg2 = bus.g2; pa1 = bus.a1; pa2 = bus.a2;
    bus.r1 = ~bus.r1; bus.r2 = ~bus.r2;
    while (n_grant < 1000 && cyc < 20000) begin
      tick();
      cyc++;
      if ((bus.g1 ^ pg1) && (bus.g2 ^ pg2)) chk("dual_grant", 1, 0);
      if (bus.g1 ^ pg1) begin chk("alt", 1, exp_port); exp_port = 2; n_grant++; end
      if (bus.g2 ^ pg2) begin chk("alt", 2, exp_port); exp_port = 1; n_grant++; end
      if (bus.a1 ^ pa1) n_ack1++;
      if (bus.a2 ^ pa2) n_ack2++;
      pg1 = bus.g1; pg2 = bus.g2; pa1 = bus.a1; pa2 = bus.a2;
      if ((bus.g1 ^ bus.d1) && (bus.g2 ^ bus.d2)) chk("excl", 1, 0);
      if (bus.g1 ^ bus.d1) begin
        if (w1 == 1) begin bus.d1 = bus.g1; w1 = 0; end else w1++;
      end
      if (bus.g2 ^ bus.d2) begin
        if (w2 == 5) begin bus.d2 = bus.g2; w2 = 0; end else w2++;
      end
      if (bus.r1 == bus.a1) bus.r1 = ~bus.r1;
      if (bus.r2 == bus.a2) bus.r2 = ~bus.r2;
    end
    chk("cont_grants", n_grant, 1000);
    diff = n_ack1 - n_ack2;
    chk("ack_balance", (diff >= -1 && diff <= 1), 1);
    chk("ack_count", (n_ack1 + n_ack2 >= 998), 1);

    // reset while in BUSY2, then a normal port-1 transfer
    rstn = 1'b0;
    bus.r1 = 0; bus.r2 = 0; bus.d1 = 0; bus.d2 = 0;
    tick();
    rstn = 1'b1;
    bus.datain2 = 8'h5A; bus.r2 = 1;
    tick();
    chk("mid_g2", hs(), 4'b0001);
    chk("mid_do", bus.dataout, 8'h5A);
    rstn = 1'b0;
    tick();
    chk("mid_rst_hs", hs(), 4'b0000);
    chk("mid_rst_do", bus.dataout, 8'h00);
    rstn = 1'b1;
    bus.r2 = 0;
    bus.datain1 = 8'h3C; bus.r1 = 1;
    tick();
    chk("post_g1", hs(), 4'b0010);
    chk("post_do", bus.dataout, 8'h3C);
    bus.d1 = 1;
    tick();
    chk("post_a1", hs(), 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
